// File: rtl/file_register_port_arbiter_pkg.sv
// Shared definitions for the file register port arbiter: FSM state
// encodings, operation codes and the hard-wired zero register index.
package file_register_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SERVE = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // MIPS $zero: writes are suppressed, reads return whatever the file drives.
  localparam int unsigned ZERO_REG_IDX = 0;

endpackage

// File: rtl/file_register_port_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter. Purely combinational; the "last served"
// pointer is owned by the parent so it only moves when a grant is taken.
module rr_arbiter_2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] grant_o,
  output logic       winner_o
);

  // Single request wins outright; on a tie the requester not served last wins.
  always_comb begin
    grant_o  = 2'b00;
    winner_o = 1'b0;
    case (req_i)
      2'b01: begin
        grant_o  = 2'b01;
        winner_o = 1'b0;
      end
      2'b10: begin
        grant_o  = 2'b10;
        winner_o = 1'b1;
      end
      2'b11: begin
        if (last_i) begin
          grant_o  = 2'b01;
          winner_o = 1'b0;
        end else begin
          grant_o  = 2'b10;
          winner_o = 1'b1;
        end
      end
      default: begin
        grant_o  = 2'b00;
        winner_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/file_register_port_arbiter.sv
// Shares the file register's single bus port between two requesters.
// Each accepted request runs IDLE -> SERVE -> DONE: one cycle of file
// register access in SERVE, a one-cycle ack (with read data) in DONE.
// All file register controls decode only from state and holding registers.
module file_register_port_arbiter
  import file_register_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0]            op,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [1:0]            ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  fr_we,
  output logic                  fr_re,
  output logic [ADDR_WIDTH-1:0] fr_read1_addr,
  output logic [ADDR_WIDTH-1:0] fr_write_addr,
  inout  wire  [DATA_WIDTH-1:0] data_bus
);

  state_e                  state_q, state_d;
  logic                    last_q;
  logic                    winner_q;
  logic                    op_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              grant_s;
  logic                    winner_s;
  logic                    accept_s;
  logic                    serve_wr_s;
  logic                    serve_rd_s;

  rr_arbiter_2 u_arb (
    .req_i    (req),
    .last_i   (last_q),
    .grant_o  (grant_s),
    .winner_o (winner_s)
  );

  assign accept_s = (state_q == ST_IDLE) && (req != 2'b00);

  // Next-state logic for the IDLE -> SERVE -> DONE sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          state_d = ST_SERVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the winner's operation and move the round-robin pointer on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q   <= 1'b1;
      winner_q <= 1'b0;
      op_q     <= OP_READ;
      addr_q   <= {ADDR_WIDTH{1'b0}};
      wdata_q  <= {DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      last_q   <= winner_s;
      winner_q <= winner_s;
      op_q     <= grant_s[1] ? op[1]  : op[0];
      addr_q   <= grant_s[1] ? addr1  : addr0;
      wdata_q  <= grant_s[1] ? wdata1 : wdata0;
    end
  end

  // Capture the bus at the edge that ends a read SERVE; held through writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= {DATA_WIDTH{1'b0}};
    end else if ((state_q == ST_SERVE) && (op_q == OP_READ)) begin
      rdata_q <= data_bus;
    end
  end

  // Decode file register controls and the ack pulse from state and holding regs.
  always_comb begin
    serve_rd_s    = (state_q == ST_SERVE) && (op_q == OP_READ);
    serve_wr_s    = (state_q == ST_SERVE) && (op_q == OP_WRITE) &&
                    (addr_q != ADDR_WIDTH'(ZERO_REG_IDX));
    fr_re         = serve_rd_s;
    fr_we         = serve_wr_s;
    fr_read1_addr = serve_rd_s ? addr_q : {ADDR_WIDTH{1'b0}};
    fr_write_addr = serve_wr_s ? addr_q : {ADDR_WIDTH{1'b0}};
    busy          = (state_q != ST_IDLE);
    if (state_q == ST_DONE) begin
      ack = winner_q ? 2'b10 : 2'b01;
    end else begin
      ack = 2'b00;
    end
  end

  assign rdata = rdata_q;

  // One tri-state driver per bus bit, enabled only for a non-$zero write SERVE.
  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_bus_drv
    bufif1 u_drv (data_bus[g], wdata_q[g], serve_wr_s);
  end

endmodule

// File: tb/tb_file_register_port_arbiter.sv
// Self-checking bench for file_register_port_arbiter. A small file register
// model drives the bus on reads and stores bus writes; a scoreboard queue
// holds the expected ack/rdata for every operation issued.
module tb_file_register_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic [1:0]    req;
  logic [1:0]    op;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    ack;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          fr_we, fr_re;
  logic [AW-1:0] fr_read1_addr, fr_write_addr;
  wire  [DW-1:0] data_bus;

  typedef struct packed {
    logic [1:0]    ack;
    logic [DW-1:0] rdata;
  } sb_item_t;

  sb_item_t      sb_q[$];
  int            vec_cnt = 0;
  int            err_cnt = 0;
  int            cyc = 0;
  logic [DW-1:0] model_rdata = 32'h0;
  logic          we_seen = 1'b0;
  logic [DW-1:0] mem [32] = '{default: 32'h0};
  logic [DW-1:0] tb_bus_val;

  file_register_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .op            (op),
    .addr0         (addr0),
    .addr1         (addr1),
    .wdata0        (wdata0),
    .wdata1        (wdata1),
    .ack           (ack),
    .rdata         (rdata),
    .busy          (busy),
    .fr_we         (fr_we),
    .fr_re         (fr_re),
    .fr_read1_addr (fr_read1_addr),
    .fr_write_addr (fr_write_addr),
    .data_bus      (data_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // File register model: drives read data while fr_re, a zero keeper otherwise;
  // releases the bus only while the controller is writing.
  always_comb tb_bus_val = fr_re ? mem[fr_read1_addr] : 32'h0;
  assign data_bus = fr_we ? {DW{1'bz}} : tb_bus_val;

  always @(posedge clk) begin
    if (fr_we && (fr_write_addr != 5'd0)) mem[fr_write_addr] <= data_bus;
  end

  // Per-cycle bus discipline checks and scoreboard comparison on each ack.
  initial begin
    sb_item_t it;
    forever begin
      @(negedge clk);
      vec_cnt++;
      if (fr_we && fr_re) begin
        err_cnt++;
        $display("FAIL we_re_exclusive: fr_we=%b fr_re=%b, required not both 1", fr_we, fr_re);
      end
      if (!fr_we) begin
        vec_cnt++;
        if (data_bus !== tb_bus_val) begin
          err_cnt++;
          $display("FAIL bus_release: data_bus=%h, required %h (controller must not drive)", data_bus, tb_bus_val);
        end
      end
      if (!busy) begin
        vec_cnt++;
        if ({fr_we, fr_re, fr_read1_addr, fr_write_addr} !== 12'h000) begin
          err_cnt++;
          $display("FAIL idle_controls: we=%b re=%b ra=%0d wa=%0d, required all 0", fr_we, fr_re, fr_read1_addr, fr_write_addr);
        end
      end
      if (fr_we) we_seen = 1'b1;
      if (ack !== 2'b00) begin
        vec_cnt++;
        if (sb_q.size() == 0) begin
          err_cnt++;
          $display("FAIL unexpected_ack: ack=%b, required 00", ack);
        end else begin
          it = sb_q.pop_front();
          if ((ack !== it.ack) || (rdata !== it.rdata)) begin
            err_cnt++;
            $display("FAIL scoreboard: ack=%b rdata=%h, required ack=%b rdata=%h", ack, rdata, it.ack, it.rdata);
          end
        end
      end
    end
  end

  task automatic push_exp(input int r);
    sb_item_t it;
    it.ack   = (r == 0) ? 2'b01 : 2'b10;
    it.rdata = model_rdata;
    sb_q.push_back(it);
  endtask

  // Issue one operation for requester r, leave req high, wait (bounded) for ack.
  task automatic do_op(input int r, input logic o, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd,
                       output int lat);
    logic got;
    if (r == 0) begin
      op[0] = o; addr0 = a; wdata0 = wd;
    end else begin
      op[1] = o; addr1 = a; wdata1 = wd;
    end
    req[r] = 1'b1;
    if (o == 1'b0) model_rdata = exp_rd;
    push_exp(r);
    lat = 0;
    got = 1'b0;
    for (int k = 0; (k < 12) && !got; k++) begin
      @(negedge clk);
      lat++;
      if (ack[r]) got = 1'b1;
    end
    vec_cnt++;
    if (!got) begin
      err_cnt++;
      $display("FAIL op_timeout: requester %0d saw no ack within 12 cycles, required an ack", r);
    end
  endtask

  task automatic go_idle();
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    req = 2'b00;
    sb_q.delete();
    model_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    vec_cnt++;
    if ({ack, busy, fr_we, fr_re} !== 5'b00000) begin
      err_cnt++;
      $display("FAIL %s_ctrl: ack=%b busy=%b we=%b re=%b, required all 0", tag, ack, busy, fr_we, fr_re);
    end
    vec_cnt++;
    if ((rdata !== 32'h0) || (fr_read1_addr !== 5'd0) || (fr_write_addr !== 5'd0)) begin
      err_cnt++;
      $display("FAIL %s_data: rdata=%h ra=%0d wa=%0d, required 0", tag, rdata, fr_read1_addr, fr_write_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 check_reset_values("reset");
    repeat (2) @(negedge clk);
    check_reset_values("reset_hold");
    rst = 1'b1;
  endtask

  task automatic test_simultaneous();
    int n;
    int who;
    int served [2];
    int lat;
    apply_reset();
    served[0] = 0;
    served[1] = 0;
    op = 2'b11;
    addr0 = 5'd6; wdata0 = 32'hA0A0_0006;
    addr1 = 5'd7; wdata1 = 32'hB0B0_0007;
    req = 2'b11;
    push_exp(0);
    push_exp(1);
    n = 0;
    for (int k = 0; (k < 30) && (n < 4); k++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        who = ack[1] ? 1 : 0;
        vec_cnt++;
        if (who != (n % 2)) begin
          err_cnt++;
          $display("FAIL rr_order: op %0d served requester %0d, required %0d", n, who, n % 2);
        end
        served[who]++;
        if (served[who] < 2) begin
          if (who == 0) begin
            addr0 = 5'd8; wdata0 = 32'hA1A1_0008;
          end else begin
            addr1 = 5'd9; wdata1 = 32'hB1B1_0009;
          end
          push_exp(who);
        end else begin
          req[who] = 1'b0;
        end
        n++;
      end
    end
    vec_cnt++;
    if (n != 4) begin
      err_cnt++;
      $display("FAIL rr_count: %0d acks, required 4", n);
    end
    go_idle();
    do_op(1, 1'b0, 5'd9, 32'h0, 32'hB1B1_0009, lat);
    go_idle();
    do_op(0, 1'b0, 5'd6, 32'h0, 32'hA0A0_0006, lat);
    go_idle();
  endtask

  task automatic test_write_read();
    int lat;
    do_op(0, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'h0, lat);
    vec_cnt++;
    if (lat !== 2) begin
      err_cnt++;
      $display("FAIL write_latency: %0d cycles, required 2", lat);
    end
    go_idle();
    do_op(0, 1'b0, 5'd5, 32'h0, 32'hDEAD_BEEF, lat);
    vec_cnt++;
    if (lat !== 2) begin
      err_cnt++;
      $display("FAIL read_latency: %0d cycles, required 2", lat);
    end
    go_idle();
  endtask

  task automatic test_zero_reg();
    int lat;
    we_seen = 1'b0;
    do_op(1, 1'b1, 5'd0, 32'h1234_5678, 32'h0, lat);
    vec_cnt++;
    if (we_seen !== 1'b0) begin
      err_cnt++;
      $display("FAIL zero_write_we: fr_we went %b, required 0", we_seen);
    end
    go_idle();
    do_op(0, 1'b0, 5'd0, 32'h0, 32'h0, lat);
    go_idle();
  endtask

  task automatic test_back_to_back();
    int lat;
    int t [3];
    do_op(1, 1'b1, 5'd1, 32'h11, 32'h0, lat);
    go_idle();
    do_op(1, 1'b1, 5'd2, 32'h22, 32'h0, lat);
    go_idle();
    do_op(1, 1'b1, 5'd3, 32'h33, 32'h0, lat);
    go_idle();
    do_op(0, 1'b0, 5'd1, 32'h0, 32'h11, lat); t[0] = cyc;
    do_op(0, 1'b0, 5'd2, 32'h0, 32'h22, lat); t[1] = cyc;
    do_op(0, 1'b0, 5'd3, 32'h0, 32'h33, lat); t[2] = cyc;
    for (int i = 1; i < 3; i++) begin
      vec_cnt++;
      if ((t[i] - t[i-1]) != 3) begin
        err_cnt++;
        $display("FAIL b2b_spacing: ack %0d came %0d cycles after previous, required 3", i, t[i] - t[i-1]);
      end
    end
    go_idle();
  endtask

  task automatic test_reset_mid_serve();
    int lat;
    op[0] = 1'b1; addr0 = 5'd10; wdata0 = 32'hCAFE_F00D;
    req[0] = 1'b1;
    @(posedge clk);
    #2;
    vec_cnt++;
    if (fr_we !== 1'b1) begin
      err_cnt++;
      $display("FAIL mid_serve_setup: fr_we=%b, required 1", fr_we);
    end
    rst = 1'b0;
    req = 2'b00;
    sb_q.delete();
    model_rdata = 32'h0;
    #1 check_reset_values("async_reset");
    repeat (3) begin
      @(negedge clk);
      check_reset_values("reset_no_ack");
    end
    rst = 1'b1;
    do_op(1, 1'b0, 5'd5, 32'h0, 32'hDEAD_BEEF, lat);
    vec_cnt++;
    if (lat !== 2) begin
      err_cnt++;
      $display("FAIL post_reset_latency: %0d cycles, required 2", lat);
    end
    go_idle();
  endtask

  initial begin
    req = 2'b00; op = 2'b00;
    addr0 = 5'd0; addr1 = 5'd0;
    wdata0 = 32'h0; wdata1 = 32'h0;
    test_reset();
    test_simultaneous();
    test_write_read();
    test_zero_reg();
    test_back_to_back();
    test_reset_mid_serve();
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (sb_q.size() != 0) begin
      err_cnt++;
      $display("FAIL sb_drain: %0d expected acks never arrived, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
